// File: rtl/quad_step_gen.sv
// quad_step_gen: quadrature rotary-encoder emulator (PmodENC transmit side).
// Accepts step commands (direction, detent count) and drives A/B quadrature
// edges at a fixed edge rate, tracks the expected wrapped position, and
// emulates a pushbutton with a fixed hold time.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  step command present
//   cmd_dir    1 = clockwise (A leads), 0 = counter-clockwise (B leads)
//   cmd_steps  detents to emit (0 legal)
//   cmd_ready  command can be accepted
//   btn_req    one-cycle button press request
//   A, B       quadrature outputs, rest state 11
//   BTN        emulated pushbutton level
//   pos        position after completed detents, 0..MAX-1
//   done       one-cycle pulse when a command completes
module quad_step_gen #(
  parameter int unsigned STEP_CYCLES = 50000,
  parameter int unsigned BTN_CYCLES  = 500000,
  parameter logic [7:0]  MAX         = 8'd120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_steps,
  output logic       cmd_ready,
  input  logic       btn_req,
  output logic       A,
  output logic       B,
  output logic       BTN,
  output logic [7:0] pos,
  output logic       done
);

  localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned BtnW  = (BTN_CYCLES > 1) ? $clog2(BTN_CYCLES) : 1;
  localparam logic [StepW-1:0] StepReload = StepW'(STEP_CYCLES - 1);
  localparam logic [BtnW-1:0]  BtnReload  = BtnW'(BTN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q;
  logic [StepW-1:0] timer_q;
  logic [1:0]       phase_q;   // edge index within the current detent
  logic [7:0]       remain_q;
  logic             dir_q;
  logic             a_q, b_q, ready_q, done_q;
  logic [7:0]       pos_q;
  logic [7:0]       pos_step;

  logic             btn_q;
  logic [BtnW-1:0]  btn_cnt_q;

  // Position after one more detent in the latched direction, wrapping modulo MAX.
  always_comb begin
    pos_step = pos_q;
    if (dir_q) begin
      pos_step = (pos_q == MAX - 8'd1) ? 8'd0 : pos_q + 8'd1;
    end else begin
      pos_step = (pos_q == 8'd0) ? MAX - 8'd1 : pos_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      phase_q  <= 2'd0;
      remain_q <= 8'd0;
      dir_q    <= 1'b0;
      a_q      <= 1'b1;
      b_q      <= 1'b1;
      pos_q    <= 8'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ready_q && cmd_valid) begin
            ready_q  <= 1'b0;
            dir_q    <= cmd_dir;
            remain_q <= cmd_steps;
            timer_q  <= StepReload;
            phase_q  <= 2'd0;
            state_q  <= (cmd_steps == 8'd0) ? StFin : StRun;
          end else begin
            // Re-arms one cycle after FIN so cmd_ready lands at T+4N*STEP+2.
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (timer_q == '0) begin
            timer_q <= StepReload;
            phase_q <= phase_q + 2'd1;
            // CW toggles A on even edges (A leads); CCW toggles A on odd edges.
            if (dir_q ^ phase_q[0]) begin
              a_q <= ~a_q;
            end else begin
              b_q <= ~b_q;
            end
            if (phase_q == 2'd3) begin
              pos_q    <= pos_step;
              remain_q <= remain_q - 8'd1;
              if (remain_q == 8'd1) begin
                state_q <= StFin;
              end
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Button hold timer: independent of stepping; requests during a hold are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= 1'b0;
      btn_cnt_q <= '0;
    end else if (btn_q) begin
      if (btn_cnt_q == '0) begin
        btn_q <= 1'b0;
      end else begin
        btn_cnt_q <= btn_cnt_q - 1'b1;
      end
    end else if (btn_req) begin
      btn_q     <= 1'b1;
      btn_cnt_q <= BtnReload;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign BTN       = btn_q;
  assign pos       = pos_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Bench for quad_step_gen: randomized commands and button requests, expected
// A/B edges and done pulses queued at issue time from an arithmetic model,
// popped and compared by an independent monitor.
module tb_quad_step_gen;

  localparam int unsigned SC  = 4;
  localparam int unsigned BC  = 10;
  localparam int unsigned MAXP = 120;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       cmd_ready;
  logic       btn_req;
  logic       A, B, BTN;
  logic [7:0] pos;
  logic       done;

  quad_step_gen #(
    .STEP_CYCLES(SC),
    .BTN_CYCLES (BC),
    .MAX        (8'd120)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready),
    .btn_req  (btn_req),
    .A        (A),
    .B        (B),
    .BTN      (BTN),
    .pos      (pos),
    .done     (done)
  );

  typedef struct {
    longint     cyc;
    logic [1:0] ab;
    logic [7:0] pos;
  } ev_t;

  ev_t    edge_q[$];
  ev_t    done_q[$];
  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  // Reference model state
  int     m_pos = 0;
  longint m_ready_at = 0;
  longint m_btn_from = -100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic bit btn_on(input longint x);
    return (x >= m_btn_from) && (x < m_btn_from + longint'(BC));
  endfunction

  function automatic int wrap_step(input int p, input bit d);
    if (d) return (p == MAXP - 1) ? 0 : p + 1;
    return (p == 0) ? MAXP - 1 : p - 1;
  endfunction

  // Expected AB after k edges of a detent sequence, indexed by k mod 4.
  function automatic logic [1:0] ab_after(input bit d, input int k);
    logic [1:0] cw_tab[4];
    logic [1:0] ccw_tab[4];
    cw_tab  = '{2'b11, 2'b01, 2'b00, 2'b10};
    ccw_tab = '{2'b11, 2'b10, 2'b00, 2'b01};
    return d ? cw_tab[k % 4] : ccw_tab[k % 4];
  endfunction

  task automatic push_cmd(input longint t, input bit d, input int n);
    int     p;
    longint dc;
    ev_t    e;
    p = m_pos;
    for (int k = 1; k <= 4 * n; k++) begin
      if (k % 4 == 0) p = wrap_step(p, d);
      e.cyc = t + longint'(k) * SC;
      e.ab  = ab_after(d, k);
      e.pos = 8'(p);
      edge_q.push_back(e);
    end
    dc    = (n == 0) ? t + 1 : t + longint'(4 * n) * SC + 1;
    e.cyc = dc;
    e.ab  = 2'b11;
    e.pos = 8'(p);
    done_q.push_back(e);
    m_pos      = p;
    m_ready_at = dc + 1;
  endtask

  // Drive one cycle's inputs (called just after a negedge) and update the model.
  task automatic apply(input bit v, input bit d, input logic [7:0] s, input bit b);
    longint x;
    x         = cyc;
    cmd_valid = v;
    cmd_dir   = d;
    cmd_steps = s;
    btn_req   = b;
    if (v && x >= m_ready_at) push_cmd(x + 1, d, int'(s));
    if (b && !btn_on(x)) m_btn_from = x + 1;
  endtask

  task automatic cycle_drive(input bit v, input bit d, input logic [7:0] s, input bit b);
    @(negedge clk);
    apply(v, d, s, b);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_drive(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic issue(input bit d, input logic [7:0] s, input bit b);
    @(negedge clk);
    while (cyc < m_ready_at) begin
      apply(1'b0, 1'b0, 8'd0, 1'b0);
      @(negedge clk);
    end
    apply(1'b1, d, s, b);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    btn_req   = 1'b0;
    edge_q.delete();
    done_q.delete();
    m_pos      = 0;
    m_ready_at = 0;
    m_btn_from = -100;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [1:0] prev_ab;
    logic [1:0] ab;
    logic       rst_s;
    ev_t        e;
    prev_ab = 2'b11;
    forever begin
      @(posedge clk);
      rst_s = rst;
      cyc++;
      #1;
      ab = {A, B};
      if (rst_s) begin
        chk("reset AB", ab, 2'b11);
        chk("reset pos", pos, 0);
        chk("reset ready", cmd_ready, 1);
        chk("reset done", done, 0);
        chk("reset BTN", BTN, 0);
      end else begin
        chk("cmd_ready", cmd_ready, (cyc >= m_ready_at) ? 1 : 0);
        chk("BTN", BTN, btn_on(cyc) ? 1 : 0);
        if (ab != prev_ab) begin
          if (edge_q.size() == 0) begin
            flag("unexpected AB edge");
          end else begin
            e = edge_q.pop_front();
            chk("edge cycle", cyc, e.cyc);
            chk("edge AB", ab, e.ab);
            chk("edge pos", pos, e.pos);
          end
        end else if (edge_q.size() > 0 && edge_q[0].cyc <= cyc) begin
          flag("missing AB edge");
          void'(edge_q.pop_front());
        end
        if (done) begin
          if (done_q.size() == 0) begin
            flag("unexpected done");
          end else begin
            e = done_q.pop_front();
            chk("done cycle", cyc, e.cyc);
            chk("done pos", pos, e.pos);
          end
        end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
          flag("missing done");
          void'(done_q.pop_front());
        end
      end
      prev_ab = ab;
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd0;
    btn_req   = 1'b0;
    do_reset(3);
    idle(20);

    // Wrap both ways from 0.
    issue(1'b0, 8'd1, 1'b0);
    issue(1'b1, 8'd1, 1'b0);

    // cw 2 with a button press, a retrigger inside the hold, and a busy cmd_valid.
    issue(1'b1, 8'd2, 1'b1);
    idle(4);
    cycle_drive(1'b1, 1'b0, 8'd3, 1'b1);
    idle(3);

    // Zero-step command.
    issue(1'b1, 8'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle_drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));
    end

    // Long command crossing the wrap point.
    issue(1'($urandom_range(0, 1)), 8'd130, 1'b0);

    // Reset in the middle of a detent.
    issue(1'b1, 8'd3, 1'b1);
    idle(5);
    do_reset(1);
    idle(3);
    issue(1'b1, 8'd1, 1'b0);

    while (cyc < m_ready_at + 2 || btn_on(cyc)) idle(1);
    idle(3);
    chk("edges outstanding", edge_q.size(), 0);
    chk("done outstanding", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
